dmem_resp: RTL
==============

Name: dmem_resp

Overview:
- Data-memory responder: the target side of the core's load/store interface.
- Accepts one request at a time over a valid/ready handshake, inserts programmable wait states, and performs byte/half/word accesses on an internal word-wide synchronous RAM.
- Returns read data, sign- or zero-extended, over a valid/ready response channel.
- Sits between the core's load/store path and the data RAM; replaces a zero-latency memory so that stall handling in the core can be exercised.

Parameters:
- ADDR_W, 20: number of byte-address bits decoded; higher address bits must be zero.
- DEPTH_WORDS, 1024: RAM depth in 32-bit words; must not exceed 2^(ADDR_W-2).
- WAIT, 2: number of wait-state cycles inserted before the RAM access (0..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid_i  in  1  request valid
- req_ready_o  out  1  responder can accept a request
- req_we_i  in  1  1 = store, 0 = load
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- req_size_i  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved (error)
- req_unsigned_i  in  1  1 = zero-extend load data, 0 = sign-extend
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  requester accepts the response
- rsp_rdata_o  out  32  extended load data; 0 for stores and for errors
- rsp_err_o  out  1  access error, qualified by rsp_valid_o
- busy_o  out  1  a transaction is in flight (state != IDLE)

Behaviour:
- Reset
  - While rst is high: state = IDLE, req_ready_o = 0, rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0, busy_o = 0, wait counter = 0.
  - RAM contents are not reset.
  - In the first cycle after rst falls, req_ready_o = 1.
- State machine: IDLE -> WAITS -> ACCESS -> RESP -> IDLE.
  - IDLE: req_ready_o = 1. On req_valid_i && req_ready_o, register we, addr, wdata, size and unsigned. Go to WAITS with counter = WAIT-1, or directly to ACCESS when WAIT = 0.
  - WAITS: decrement the counter each cycle; go to ACCESS when the counter is 0. Lasts exactly WAIT cycles.
  - ACCESS: one cycle. Error check runs, then the RAM read or strobed write. A write commits at the end of this cycle only if no error.
  - RESP: rsp_valid_o = 1. rsp_rdata_o and rsp_err_o are held stable until rsp_valid_o && rsp_ready_i, then return to IDLE.
- Latency: the response is visible WAIT+2 cycles after the accepting cycle, when rsp_ready_i is held high.
- req_ready_o = 0 in every state except IDLE. No new request is accepted in the same cycle as a response handshake; the next accept is one cycle later, in IDLE.
- Byte lanes: lane = addr[1:0].
  - Byte store: write wdata[7:0] to the selected lane only.
  - Half store: write wdata[15:0] to lanes {addr[1],0}+1 and {addr[1],0}.
  - Word store: write all four lanes.
  - Loads extract the same lanes, then extend from bit 7 or bit 15 according to req_unsigned_i. Word loads are passed through unchanged.
- Errors, any one of which sets rsp_err_o = 1, gives rdata = 0 and suppresses the write:
  - size = 11;
  - addr[31:ADDR_W] != 0;
  - word index addr[ADDR_W-1:2] >= DEPTH_WORDS;
  - misalignment, as defined under the optional feature.
- Reset in WAITS or ACCESS: a store is dropped unless it reached the end of its ACCESS cycle. Reset in RESP: the pending response is discarded.
- A request held on req_valid_i while busy is ignored; it is accepted in IDLE.

Optional Feature:
- Macro: DMEM_ALIGN_CHK_EN.
- Defined: half access with addr[0] = 1, or word access with addr[1:0] != 00, is an error (rsp_err_o = 1, no write, rdata = 0).
- Not defined: the offending low address bits are forced to zero (half uses addr[1] only; word uses lane 0). The access completes normally with rsp_err_o = 0.

Test Plan:
- Word store then load, WAIT=2: store 0xDEADBEEF to 0x100, then load 0x100 -> rdata = 0xDEADBEEF, err = 0. rsp_valid_o rises exactly 4 cycles after each accept.
- Byte store 0x80 to 0x101 over an existing word 0x00000000, then load byte signed from 0x101 -> 0xFFFFFF80. Unsigned -> 0x00000080. Load word 0x100 -> 0x00008000.
- Back-pressure: hold rsp_ready_i = 0 for 5 cycles in RESP -> rsp_valid_o, rdata and err stay stable, req_ready_o = 0. Raise ready -> IDLE the next cycle.
- Errors: load from word index DEPTH_WORDS (0x1000) -> err = 1, rdata = 0. Store to 0x0010_0000 -> err = 1, and a subsequent read of 0x0 is unchanged.
- Misaligned word store 0x11223344 to 0x102:
  - with DMEM_ALIGN_CHK_EN -> err = 1 and word 0x100 unchanged;
  - without it -> err = 0 and word 0x100 = 0x11223344.
- Reset asserted in WAITS during a store of 0xCAFEF00D to 0x200 -> a later load of 0x200 returns the old value, rsp_valid_o = 0 during reset, req_ready_o = 1 the cycle after release.

Source files
------------

// File: rtl/dmem_resp_if.sv
// Load/store request and response channels between the core (master) and the
// data-memory responder (slave). Signal suffixes are from the responder's side.
interface dmem_resp_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_size_i,
               req_unsigned_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_size_i,
               req_unsigned_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );
endinterface

// File: rtl/dmem_resp.sv
// Data-memory responder: one request at a time, WAIT wait states, byte/half/word
// access to a word-wide synchronous RAM. Define DMEM_ALIGN_CHK_EN to make misaligned accesses errors.
module dmem_resp #(
    parameter int ADDR_W      = 20,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT        = 2
) (
    input  logic          clk,
    input  logic          rst,
    dmem_resp_if.slave    bus,
    output logic          busy_o
);
    localparam int IDX_W  = ADDR_W - 2;
    localparam int MEM_AW = $clog2(DEPTH_WORDS);
    // One extra bit so DEPTH_WORDS == 2^IDX_W still compares correctly.
    localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAITS, S_ACCESS, S_RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        err_q;
    logic [31:0] ram_q;
    logic [31:0] mem [DEPTH_WORDS];

    logic             accept;
    logic [IDX_W-1:0] word_idx;
    logic [MEM_AW-1:0] mem_idx;
    logic             acc_err;
    logic             wr_en;
    logic [1:0]       lane;
    logic [3:0]       be;
    logic [31:0]      wd;
    logic [31:0]      shifted;
    logic [31:0]      ext;

    assign bus.req_ready_o = (state_q == S_IDLE) && !rst;
    assign accept          = bus.req_valid_i && bus.req_ready_o;
    assign busy_o          = (state_q != S_IDLE) && !rst;
    assign word_idx        = addr_q[ADDR_W-1:2];
    assign mem_idx         = word_idx[MEM_AW-1:0];

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (WAIT == 0) begin
                        state_d = S_ACCESS;
                    end else begin
                        state_d = S_WAITS;
                        cnt_d   = 4'(WAIT - 1);
                    end
                end
            end
            S_WAITS: begin
                if (cnt_q == 4'd0) state_d = S_ACCESS;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_ACCESS: state_d = S_RESP;
            S_RESP:   if (bus.rsp_ready_i) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

`ifdef DMEM_ALIGN_CHK_EN
    logic misalign;
    assign misalign = ((size_q == 2'b01) && addr_q[0]) ||
                      ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
    assign acc_err  = (size_q == 2'b11) || (|addr_q[31:ADDR_W]) ||
                      ({1'b0, word_idx} >= DEPTH_L) || misalign;
`else
    assign acc_err  = (size_q == 2'b11) || (|addr_q[31:ADDR_W]) ||
                      ({1'b0, word_idx} >= DEPTH_L);
`endif

    // Lane selection and store-data replication; misaligned low bits are dropped.
    always_comb begin
        lane = 2'b00;
        be   = 4'hF;
        wd   = wdata_q;
        unique case (size_q)
            2'b00: begin
                lane = addr_q[1:0];
                be   = 4'b0001 << lane;
                wd   = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                lane = {addr_q[1], 1'b0};
                be   = 4'b0011 << lane;
                wd   = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted = ram_q >> {lane, 3'b000};
        unique case (size_q)
            2'b00:   ext = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
            2'b01:   ext = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
            default: ext = ram_q;
        endcase
    end

    assign wr_en = (state_q == S_ACCESS) && we_q && !acc_err && !rst;

    // NOTE: RAM contents are never reset; only control state is.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[mem_idx][8*b +: 8] <= wd[8*b +: 8];
            end
        end
        if (state_q == S_ACCESS) ram_q <= mem[mem_idx];
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= bus.req_we_i;
                addr_q  <= bus.req_addr_i;
                wdata_q <= bus.req_wdata_i;
                size_q  <= bus.req_size_i;
                uns_q   <= bus.req_unsigned_i;
            end
            if (state_q == S_ACCESS) err_q <= acc_err;
        end
    end

    assign bus.rsp_valid_o = (state_q == S_RESP) && !rst;
    assign bus.rsp_err_o   = bus.rsp_valid_o && err_q;
    assign bus.rsp_rdata_o = (bus.rsp_valid_o && !err_q && !we_q) ? ext : 32'd0;
endmodule
